// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and receiver state type (PARITY state exists only with UART_RX_PARITY_EN)
package uart_rx_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK = 8;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x-oversampled 8N1 receiver feeding a FWFT FIFO; UART_RX_PARITY_EN adds a parity bit
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int FifoDepth = 8,
  parameter int DivWidth = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DivWidth-1:0]          baud_div_i,
  input  logic                         rx_i,
`ifdef UART_RX_PARITY_EN
  input  logic                         parity_odd_i,
  output logic                         parity_err_o,
`endif
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         frame_err_o,
  output logic                         overrun_o,
  input  logic                         ovr_clr_i,
  output logic [$clog2(FifoDepth):0]   level_o
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_e state, state_n;
  logic s1, s2, tick, mid, bit_end, push, ferr_set, good, full, empty, pop;
  logic [DivWidth-1:0] cnt, div_q, div_eff;
  logic [OW-1:0] os;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  assign div_eff = baud_div_i == '0 ? DivWidth'(1) : baud_div_i;
  assign tick = state != IDLE && cnt == div_q - 1'b1;
  assign mid = tick && os == OW'(MID_TICK-1);
  assign bit_end = tick && os == OW'(OVERSAMPLE-1);
  assign valid_o = !empty;
  assign pop = valid_o && ready_i;
  always_ff @(posedge CLK) state <= RST ? IDLE : state_n;
  always_comb begin
    state_n = state;
    push = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: state_n = s2 ? IDLE : START;
      START: if (mid) state_n = s2 ? IDLE : DATA;
      DATA: if (bit_end && bit_idx == BW'(DATA_BITS-1))
`ifdef UART_RX_PARITY_EN
        state_n = PARITY;
      PARITY: if (bit_end) state_n = STOP;
`else
        state_n = STOP;
`endif
      STOP: if (bit_end) begin
        state_n = s2 ? IDLE : WAIT_HIGH;
        push = s2 && good;
        ferr_set = !s2;
      end
      WAIT_HIGH: state_n = s2 ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      {s1, s2} <= 2'b11;
      cnt <= '0;
      div_q <= div_eff;
      os <= '0;
      bit_idx <= '0;
      shreg <= '0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      {s1, s2} <= {rx_i, s1};
      frame_err_o <= ferr_set;
      overrun_o <= (push && full && !pop) ? 1'b1 : ovr_clr_i ? 1'b0 : overrun_o;
      if (state == IDLE) begin
        cnt <= '0;
        div_q <= div_eff;
        os <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        cnt <= '0;
        div_q <= div_eff;
        os <= (state == START && mid) ? '0 : os + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == DATA && bit_end) begin
        shreg <= {s2, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign good = !par_bad;
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bad <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (state == PARITY && bit_end) par_bad <= ^shreg ^ s2 ^ parity_odd_i;
      parity_err_o <= state == STOP && bit_end && par_bad;
    end
  end
`else
  assign good = 1'b1;
`endif
  uart_rx_fifo #(.WIDTH(8), .DEPTH(FifoDepth)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .din(shreg),
    .dout(data_o),
    .full(full),
    .empty(empty),
    .level(level_o)
  );
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scoreboard bench for uart_rx_deframer; frames are built from bit lists, expected bytes queued at issue
module tb_uart_rx_deframer;
  localparam int DEPTH = 8;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [15:0] baud_div_i = 16'd4;
  logic rx_i = 1'b1;
  logic [7:0] data_o;
  logic valid_o;
  logic ready_i = 1'b0;
  logic frame_err_o;
  logic overrun_o;
  logic ovr_clr_i = 1'b0;
  logic [3:0] level_o;
`ifdef UART_RX_PARITY_EN
  logic parity_odd_i = 1'b0;
  logic parity_err_o;
  int perr_cnt = 0;
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  logic par_flip = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] last_pop = 8'h00;
  logic pop_planned = 1'b0;
  logic exp_ovr = 1'b0;

  uart_rx_deframer #(.FifoDepth(DEPTH), .DivWidth(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .baud_div_i(baud_div_i),
    .rx_i(rx_i),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i(parity_odd_i),
    .parity_err_o(parity_err_o),
`endif
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .ovr_clr_i(ovr_clr_i),
    .level_o(level_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int bit_len();
    return 16 * (baud_div_i == 16'd0 ? 1 : int'(baud_div_i));
  endfunction

  // Clock edge (counted from the frame's first edge) at which the stop bit is sampled mid-bit:
  // two synchronizer edges, one edge to leave IDLE, then 8 ticks to mid start plus 16 per later bit.
  function automatic int stop_edge();
    return 3 + (bit_len() / 16) * (8 + 16 * (NBITS - 1));
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (frame_err_o) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) perr_cnt++;
`endif
      if (valid_o) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got %02h, expected none", data_o);
        end else begin
          check("head_byte", data_o, sb[0]);
          if (ready_i) begin
            last_pop = data_o;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic drive_frame(input logic [7:0] b, input logic stop_b);
    logic [11:0] bits;
    int bl;
    bl = bit_len();
`ifdef UART_RX_PARITY_EN
    bits = {1'b1, stop_b, ^b ^ parity_odd_i ^ par_flip, b, 1'b0};
`else
    bits = {2'b11, stop_b, b, 1'b0};
`endif
    @(posedge CLK);
    #1;
    for (int i = 0; i < NBITS; i++) begin
      rx_i = bits[i];
      repeat (bl) @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    if (sb.size() < DEPTH || pop_planned) sb.push_back(b);
    else exp_ovr = 1'b1;
    drive_frame(b, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    ready_i = 1'b1;
    while (sb.size() > 0 && k < 4000) begin
      @(posedge CLK);
      k++;
    end
    #1 ready_i = 1'b0;
    check("drain_done", sb.size(), 0);
  endtask

  task automatic pulse_ready_at_push();
    @(posedge CLK);
    repeat (stop_edge() - 1) @(posedge CLK);
    #1 ready_i = 1'b1;
    @(posedge CLK);
    #1 ready_i = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    fork
      send(8'hA5);
      begin
        @(posedge CLK);
        repeat (stop_edge() - 1) @(posedge CLK);
        @(negedge CLK);
        check("a5_pre_valid", valid_o, 0);
        @(negedge CLK);
        check("a5_valid", valid_o, 1);
        check("a5_data", data_o, 8'hA5);
        check("a5_level", level_o, 1);
      end
    join
    @(posedge CLK);
    #1 ready_i = 1'b1;
    @(posedge CLK);
    #1 ready_i = 1'b0;
    @(negedge CLK);
    check("a5_pop_level", level_o, 0);

    f0 = ferr_cnt;
    @(posedge CLK);
    #1 rx_i = 1'b0;
    repeat (20) @(posedge CLK);
    #1 rx_i = 1'b1;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    check("glitch_valid", valid_o, 0);
    check("glitch_ferr", ferr_cnt, f0);

    f0 = ferr_cnt;
    drive_frame(8'h3C, 1'b0);
    repeat (3 * bit_len()) @(posedge CLK);
    #1 rx_i = 1'b1;
    repeat (64) @(posedge CLK);
    @(negedge CLK);
    check("break_ferr_once", ferr_cnt, f0 + 1);
    check("break_level", level_o, 0);
    @(posedge CLK);
    #1;
    send(8'h11);
    drain();
    check("after_break_byte", last_pop, 8'h11);

    exp_ovr = 1'b0;
    for (int i = 1; i <= 9; i++) send(8'(i));
    @(negedge CLK);
    check("ovr_level", level_o, DEPTH);
    check("ovr_flag", overrun_o, exp_ovr);
    @(posedge CLK);
    #1 ovr_clr_i = 1'b1;
    @(posedge CLK);
    #1 ovr_clr_i = 1'b0;
    @(negedge CLK);
    check("ovr_clear", overrun_o, 0);
    @(posedge CLK);
    #1;
    drain();
    check("ovr_last_byte", last_pop, 8'h08);

    exp_ovr = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    pop_planned = 1'b1;
    fork
      send(8'h09);
      pulse_ready_at_push();
    join
    pop_planned = 1'b0;
    @(negedge CLK);
    check("full_pop_level", level_o, DEPTH);
    check("full_pop_ovr", overrun_o, exp_ovr);
    @(posedge CLK);
    #1;
    drain();
    check("full_pop_last", last_pop, 8'h09);

    f0 = ferr_cnt;
    fork
      drive_frame(8'hFF, 1'b1);
      begin
        @(posedge CLK);
        repeat (bit_len() * 5 + bit_len() / 2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
      end
    join
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("midrst_valid", valid_o, 0);
    check("midrst_level", level_o, 0);
    check("midrst_ferr", ferr_cnt, f0);
    @(posedge CLK);
    #1;
    send(8'h5A);
    drain();
    check("midrst_next", last_pop, 8'h5A);

    for (int n = 0; n < 6; n++) begin
      logic [7:0] b;
      baud_div_i = 16'($urandom_range(0, 3));
      b = 8'($urandom);
      fork
        send(b);
        begin
          repeat (bit_len() * NBITS) begin
            @(posedge CLK);
            #1 ready_i = 1'($urandom_range(0, 1));
          end
          ready_i = 1'b0;
        end
      join
    end
    drain();
    @(negedge CLK);
    check("rand_level", level_o, 0);

`ifdef UART_RX_PARITY_EN
    begin
      int p0;
      baud_div_i = 16'd4;
      parity_odd_i = 1'b0;
      par_flip = 1'b1;
      p0 = perr_cnt;
      drive_frame(8'h07, 1'b1);
      repeat (16) @(posedge CLK);
      @(negedge CLK);
      check("parity_err_once", perr_cnt, p0 + 1);
      check("parity_no_push", level_o, 0);
      par_flip = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
